// File: rtl/counter_mod_n_down.sv
// rtl/counter_mod_n_down.sv - loadable mod-N down counter/timer with periodic and one-shot modes
// Counts MOD_VALUE-1 down to 0 while running; tc is the combinational borrow for cascading.
module counter_mod_n_down #(
  parameter int WIDTH     = 8,
  parameter int MOD_VALUE = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] RELOAD = WIDTH'(MOD_VALUE - 1);
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             at_zero;
  logic             step;

  assign at_zero = (count_q == '0);
  // A decrement slot: running and enabled, not pre-empted by stop.
  assign step    = (state_q == RUN) && en && !stop;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc      = step && at_zero && !load;

    // Clamp compare is widened so MOD_VALUE = 2**WIDTH does not truncate.
    if (load) begin
      if (32'(load_value) > 32'(MOD_VALUE - 1)) begin
        count_d = RELOAD;
      end else begin
        count_d = load_value;
      end
    end else if (step) begin
      if (at_zero) begin
        count_d = oneshot ? '0 : RELOAD;
      end else begin
        count_d = count_q - ONE;
      end
    end

    case (state_q)
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tc && oneshot) begin
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        if (start && !stop) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= RELOAD;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_counter_mod_n_down.sv
// tb/tb_counter_mod_n_down.sv - scoreboard bench for counter_mod_n_down
// A reference model predicts each cycle; predictions are queued and compared after the edge.
module tb_counter_mod_n_down;

  localparam int W = 8;
  localparam int M = 100;

  logic         clk = 1'b0;
  logic         rst_n, en, start, stop, load, oneshot;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         tc, busy, done;

  counter_mod_n_down #(.WIDTH(W), .MOD_VALUE(M)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .start      (start),
    .stop       (stop),
    .load       (load),
    .load_value (load_value),
    .oneshot    (oneshot),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    bit busy;
    bit done;
  } exp_t;

  exp_t sb[$];
  int   tc_at[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_count = M - 1;
  int   m_state = 0;  // 0 idle, 1 run, 2 done
  int   cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulses_off();
    start = 1'b0;
    stop  = 1'b0;
    load  = 1'b0;
  endtask

  // One clock: check tc combinationally, predict the next state, compare after the edge.
  task automatic tick();
    exp_t e;
    bit   exp_tc;
    int   nc;
    int   ns;
    #1;
    cyc++;
    exp_tc = (m_state == 1) && en && (m_count == 0) && !load && !stop;
    if (rst_n) check("tc", tc, exp_tc);
    if (tc === 1'b1) tc_at.push_back(cyc);
    nc = m_count;
    ns = m_state;
    if (!rst_n) begin
      nc = M - 1;
      ns = 0;
    end else begin
      if (load) nc = (int'(load_value) > M - 1) ? M - 1 : int'(load_value);
      else if (m_state == 1 && en && !stop) begin
        if (m_count == 0) nc = oneshot ? 0 : M - 1;
        else nc = m_count - 1;
      end
      if (m_state == 1) begin
        if (stop) ns = 0;
        else if (exp_tc && oneshot) ns = 2;
      end else if (start && !stop) begin
        ns = 1;
      end
    end
    e.count = nc;
    e.busy  = (ns == 1);
    e.done  = (ns == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("count", 32'(count), e.count);
    check("busy", 32'(busy), 32'(e.busy));
    check("done", 32'(done), 32'(e.done));
    m_count = nc;
    m_state = ns;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; oneshot = 1'b0; load_value = '0;
    pulses_off();
    @(negedge clk);

    // T1: reset dominates start and load
    start = 1'b1; load = 1'b1; load_value = 8'd17;
    tick(); tick();
    rst_n = 1'b1; pulses_off();
    #1;
    check("t1_count", 32'(count), 99);
    check("t1_busy", 32'(busy), 0);
    check("t1_done", 32'(done), 0);
    check("t1_tc", 32'(tc), 0);

    // T2: periodic, tc on the 100th and 200th running cycle
    start = 1'b1; en = 1'b1; oneshot = 1'b0;
    tick();
    pulses_off();
    cyc = 0; tc_at.delete();
    for (int i = 0; i < 250; i++) tick();
    check("t2_tc_count", tc_at.size(), 2);
    if (tc_at.size() == 2) begin
      check("t2_tc_first", tc_at[0], 100);
      check("t2_tc_second", tc_at[1], 200);
    end
    check("t2_busy", 32'(busy), 1);

    // T3: one-shot from 5
    stop = 1'b1; tick(); pulses_off();
    load = 1'b1; load_value = 8'd5; tick(); pulses_off();
    start = 1'b1; oneshot = 1'b1; en = 1'b1; tick(); pulses_off();
    tc_at.delete();
    for (int i = 0; i < 16; i++) tick();
    check("t3_tc_count", tc_at.size(), 1);
    check("t3_done", 32'(done), 1);
    check("t3_busy", 32'(busy), 0);
    check("t3_count", 32'(count), 0);

    // T4: enable gating, 200 clocks at half duty give a single tc
    load = 1'b1; load_value = 8'd99; en = 1'b0; tick(); pulses_off();
    start = 1'b1; oneshot = 1'b0; tick(); pulses_off();
    tc_at.delete();
    for (int i = 0; i < 200; i++) begin
      en = (i % 2 == 0);
      tick();
    end
    check("t4_tc_count", tc_at.size(), 1);
    check("t4_busy", 32'(busy), 1);

    // T5: clamp, load in the wrap cycle, stop+start collision
    stop = 1'b1; tick(); pulses_off();
    load = 1'b1; load_value = 8'd250; tick(); pulses_off();
    check("t5_clamp", 32'(count), 99);
    load = 1'b1; load_value = 8'd1; tick(); pulses_off();
    start = 1'b1; en = 1'b0; tick(); pulses_off();
    en = 1'b1; tick();
    check("t5_at_zero", 32'(count), 0);
    tc_at.delete();
    load = 1'b1; load_value = 8'd7; tick(); pulses_off();
    check("t5_wrap_load_tc", tc_at.size(), 0);
    check("t5_wrap_load_count", 32'(count), 7);
    start = 1'b1; stop = 1'b1; tick(); pulses_off();
    check("t5_collide_busy", 32'(busy), 0);
    check("t5_collide_count", 32'(count), 7);

    // T6: reset mid-count, then resume
    load = 1'b1; load_value = 8'd99; en = 1'b0; tick(); pulses_off();
    start = 1'b1; tick(); pulses_off();
    en = 1'b1;
    for (int i = 0; i < 57; i++) tick();
    check("t6_pre_reset", 32'(count), 42);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t6_reset_count", 32'(count), 99);
    check("t6_reset_busy", 32'(busy), 0);
    start = 1'b1; tick(); pulses_off();
    for (int i = 0; i < 3; i++) tick();
    check("t6_resume", 32'(count), 96);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
